wifi_tx_sipo_symbol_packer: RTL and testbench
=============================================

# wifi_tx_sipo_symbol_packer

Transmit-side serial-in/parallel-out packer for the WIFI PHY. It collects the serial scrambled/coded bit stream into bit groups sized for the selected constellation: BPSK 1 bit, QPSK 2, 16-QAM 4 or 64-QAM 6. It presents each group as one parallel symbol word to the constellation mapper. It is the exact inverse of the RX-side parallel-to-serial demapper path: the first bit received becomes the symbol MSB.

## Interface

- MAX_BPS, 6, width of the symbol word. Fixed at 6; not intended to be overridden.
- SYMCNT_W, 16, width of the per-burst symbol counter.

- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in is valid this cycle.
- data_in  input  1  serial bit.
- last_in  input  1  qualified by valid_in; marks the final bit of the burst.
- mod_sel  input  2  selects bits per symbol (bps): 00 BPSK (1), 01 QPSK (2), 10 16-QAM (4), 11 64-QAM (6).
- valid_out  output  1  one-cycle pulse; a symbol is on data_out.
- data_out  output  MAX_BPS  symbol word, right-justified; bits [MAX_BPS-1:bps] are 0.
- last_out  output  1  this symbol is the last of the burst.
- pad_out  output  1  this symbol was zero-padded because the burst ended early.
- sym_count  output  SYMCNT_W  number of symbols emitted in the current burst.
- busy  output  1  partial symbol held (state FILL).

## Operation

- **States**
  - IDLE: bit counter = 0.
  - FILL: 1 ≤ bit counter < bps.
- **Latching bps:** bps is latched from mod_sel on the accepted bit that leaves IDLE. A mod_sel change while in FILL is ignored until the next IDLE.
- **Accepting a bit:** on valid_in, the shift register shifts left by one and data_in enters at bit 0. After bps accepted bits, the first bit sits at data_out[bps-1] and the last at data_out[0].
  - Example, QPSK: bits b0 then b1 give data_out[1]=b0, data_out[0]=b1.
- **Completion:** when the accepted bit makes the count equal bps:
  - on the next cycle valid_out=1, with data_out holding the group;
  - the counter returns to 0 and the state to IDLE.
- **Gaps:** valid_in low mid-symbol holds all state. Gaps of any length are legal; nothing is discarded.
- **last_in on a completing bit:** the symbol is emitted normally with last_out=1 and pad_out=0.
- **last_in on a non-completing bit:**
  - the missing low-order positions are filled with 0, i.e. the partial group is left-shifted by (bps − count);
  - the symbol is emitted on the next cycle with last_out=1 and pad_out=1;
  - the state returns to IDLE.
- **sym_count:**
  - increments by 1 with every valid_out;
  - the cycle after a valid_out with last_out=1, it clears to 0;
  - it wraps modulo 2^SYMCNT_W.
- **Outputs when idle:** data_out, last_out and pad_out are 0 whenever valid_out is 0.
- **BPSK:** every accepted bit completes a symbol and FILL is never entered. last_in gives pad_out=0.

## Timing

- **Reset values:** reset low drives valid_out=0, data_out=0, last_out=0, pad_out=0, sym_count=0, busy=0, bit counter=0, latched bps=1, state IDLE.
- **Reset mid-symbol:** the partial symbol is discarded and no output is produced.
- **Latency:** exactly 1 clock from the completing (or last_in) bit to valid_out. Throughput is up to 1 bit per clock.
- **Back-to-back symbols:** a new bit in the same cycle valid_out is high is accepted normally. In BPSK, valid_out can stay high on consecutive cycles.
- **busy:** registered; reflects the state after the current edge.
- **Downstream:** no backpressure. The mapper must accept every valid_out pulse.

## Test plan

- **QPSK stream:** mod_sel=01, continuous bits 1,0,0,1,1,1 → valid_out on cycles 2, 4 and 6 after the first bit, with data_out=000010, 000001, 000011, and sym_count 1, 2, 3.
- **16-QAM with gaps:** mod_sel=10, bits 1,1,0,1 with valid_in low for 3 cycles after bit 2 → a single valid_out, data_out=001101, 1 cycle after bit 4.
- **Early end (16-QAM):** bits 1,0,1 with last_in on the third bit → data_out=001010, last_out=1, pad_out=1; sym_count reads 0 the following cycle.
- **64-QAM exact end plus mod_sel change:** mod_sel=11, 6 bits 101100 with last_in on bit 6; mod_sel toggles to 00 at bit 3.
  - → data_out=101100, last_out=1, pad_out=0.
  - Next burst: a single BPSK bit 1 gives data_out=000001.
- **BPSK back-to-back:** mod_sel=00, bits 1,0,1 on consecutive cycles → valid_out high for 3 cycles with data_out=000001, 000000, 000001.
- **Reset mid-symbol:** 64-QAM, 3 bits in, then assert reset → all outputs 0 and busy=0. Six new bits 111111 → a single symbol 111111 with pad_out=0.

Source files
------------

// File: rtl/wifi_tx_sipo_symbol_packer.sv
// rtl/wifi_tx_sipo_symbol_packer.sv - serial-in/parallel-out packer from coded bits to constellation symbol words
module wifi_tx_sipo_symbol_packer #(
    parameter int MAX_BPS  = 6,
    parameter int SYMCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                data_in,
    input  logic                last_in,
    input  logic [1:0]          mod_sel,
    output logic                valid_out,
    output logic [MAX_BPS-1:0]  data_out,
    output logic                last_out,
    output logic                pad_out,
    output logic [SYMCNT_W-1:0] sym_count,
    output logic                busy
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [2:0]          bps_q;
    // Holds at most bps-1 bits: a group is emitted as soon as it completes.
    logic [MAX_BPS-2:0]  shreg;

    logic [2:0]          bps_dec;
    logic [2:0]          bps_eff;
    logic [2:0]          cnt_next;
    logic [2:0]          pad_shift;
    logic [MAX_BPS-1:0]  sh_next;
    logic [MAX_BPS-1:0]  sh_padded;
    logic                complete;
    logic [SYMCNT_W-1:0] sym_base;

    // Next-bit datapath: decode bps, append the incoming bit, derive completion and padding.
    always_comb begin
        case (mod_sel)
            2'b00:   bps_dec = 3'd1;
            2'b01:   bps_dec = 3'd2;
            2'b10:   bps_dec = 3'd4;
            default: bps_dec = 3'd6;
        endcase
        // mod_sel only matters on the bit that starts a symbol.
        bps_eff   = (state == IDLE) ? bps_dec : bps_q;
        cnt_next  = bit_cnt + 3'd1;
        // shreg is zero in IDLE, so the group is right-justified with zero upper bits.
        sh_next   = {shreg, data_in};
        complete  = (cnt_next == bps_eff);
        pad_shift = bps_eff - cnt_next;
        sh_padded = sh_next << pad_shift;
        // The counter restarts on the cycle following a burst-final symbol.
        sym_base  = (valid_out && last_out) ? '0 : sym_count;
    end

    // Symbol assembly FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            bps_q     <= 3'd1;
            shreg     <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
            pad_out   <= 1'b0;
            sym_count <= '0;
            busy      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
            pad_out   <= 1'b0;
            sym_count <= sym_base;
            if (valid_in) begin
                if (state == IDLE) begin
                    bps_q <= bps_dec;
                end
                if (complete || last_in) begin
                    valid_out <= 1'b1;
                    data_out  <= complete ? sh_next : sh_padded;
                    last_out  <= last_in;
                    pad_out   <= last_in && !complete;
                    sym_count <= sym_base + SYMCNT_W'(1);
                    bit_cnt   <= 3'd0;
                    shreg     <= '0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end else begin
                    shreg     <= sh_next[MAX_BPS-2:0];
                    bit_cnt   <= cnt_next;
                    state     <= FILL;
                    busy      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wifi_tx_sipo_symbol_packer.sv
// tb/tb_wifi_tx_sipo_symbol_packer.sv - directed self-checking bench for wifi_tx_sipo_symbol_packer
module tb_wifi_tx_sipo_symbol_packer;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        data_in;
    logic        last_in;
    logic [1:0]  mod_sel;
    logic        valid_out;
    logic [5:0]  data_out;
    logic        last_out;
    logic        pad_out;
    logic [15:0] sym_count;
    logic        busy;

    int errors;
    int checks;

    wifi_tx_sipo_symbol_packer dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .mod_sel   (mod_sel),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .pad_out   (pad_out),
        .sym_count (sym_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then sample #1 after the capturing edge.
    task automatic step(input logic v, input logic d, input logic l, input logic [1:0] m);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        last_in  = l;
        mod_sel  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 1'b0;
        last_in  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_sym(input string tag, input logic [5:0] d, input logic l, input logic p,
                             input logic [15:0] sc);
        check({tag, ".valid"}, valid_out, 1'b1);
        check({tag, ".data"},  data_out, d);
        check({tag, ".last"},  last_out, l);
        check({tag, ".pad"},   pad_out, p);
        check({tag, ".cnt"},   sym_count, sc);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 1'b0;
        last_in  = 1'b0;
        mod_sel  = 2'b00;
        #12;
        check("rst.valid", valid_out, 1'b0);
        check("rst.data",  data_out, 6'd0);
        check("rst.last",  last_out, 1'b0);
        check("rst.pad",   pad_out, 1'b0);
        check("rst.cnt",   sym_count, 16'd0);
        check("rst.busy",  busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // QPSK continuous 1,0,0,1,1,1
        step(1, 1, 0, 2'b01);
        check("qpsk.b0.valid", valid_out, 1'b0);
        check("qpsk.b0.busy",  busy, 1'b1);
        step(1, 0, 0, 2'b01);
        check_sym("qpsk.s0", 6'b000010, 0, 0, 16'd1);
        check("qpsk.s0.busy", busy, 1'b0);
        step(1, 0, 0, 2'b01);
        check("qpsk.b2.valid", valid_out, 1'b0);
        step(1, 1, 0, 2'b01);
        check_sym("qpsk.s1", 6'b000001, 0, 0, 16'd2);
        step(1, 1, 0, 2'b01);
        step(1, 1, 0, 2'b01);
        check_sym("qpsk.s2", 6'b000011, 0, 0, 16'd3);
        step(0, 0, 0, 2'b01);
        check("qpsk.idle.data", data_out, 6'd0);
        check("qpsk.hold.cnt", sym_count, 16'd3);

        // 16-QAM with a 3-cycle gap after bit 2
        do_reset();
        step(1, 1, 0, 2'b10);
        step(1, 1, 0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2'b10);
            check("gap.valid", valid_out, 1'b0);
            check("gap.busy",  busy, 1'b1);
        end
        step(1, 0, 0, 2'b10);
        check("gap.b2.valid", valid_out, 1'b0);
        step(1, 1, 0, 2'b10);
        check_sym("gap.s0", 6'b001101, 0, 0, 16'd1);

        // 16-QAM early end: 1,0,1 with last on bit 3
        do_reset();
        step(1, 1, 0, 2'b10);
        step(1, 0, 0, 2'b10);
        step(1, 1, 1, 2'b10);
        check_sym("early", 6'b001010, 1, 1, 16'd1);
        check("early.busy", busy, 1'b0);
        step(0, 0, 0, 2'b10);
        check("early.after.cnt",   sym_count, 16'd0);
        check("early.after.valid", valid_out, 1'b0);
        check("early.after.last",  last_out, 1'b0);

        // 64-QAM early end after a single bit: shift by 5
        step(1, 1, 1, 2'b11);
        check_sym("early1", 6'b100000, 1, 1, 16'd1);

        // 64-QAM 101100 exact end, mod_sel toggled to BPSK at bit 3
        do_reset();
        step(1, 1, 0, 2'b11);
        step(1, 0, 0, 2'b11);
        step(1, 1, 0, 2'b00);
        check("q64.b2.valid", valid_out, 1'b0);
        step(1, 1, 0, 2'b00);
        step(1, 0, 0, 2'b00);
        check("q64.b4.busy", busy, 1'b1);
        step(1, 0, 1, 2'b00);
        check_sym("q64", 6'b101100, 1, 0, 16'd1);
        step(1, 1, 0, 2'b00);
        check_sym("q64.next", 6'b000001, 0, 0, 16'd1);

        // BPSK back-to-back 1,0,1 with last on the third bit
        do_reset();
        step(1, 1, 0, 2'b00);
        check_sym("bpsk.s0", 6'b000001, 0, 0, 16'd1);
        check("bpsk.busy", busy, 1'b0);
        step(1, 0, 0, 2'b00);
        check_sym("bpsk.s1", 6'b000000, 0, 0, 16'd2);
        step(1, 1, 1, 2'b00);
        check_sym("bpsk.s2", 6'b000001, 1, 0, 16'd3);

        // Reset mid-symbol in 64-QAM, then a clean six-bit symbol
        do_reset();
        step(1, 1, 0, 2'b11);
        step(1, 1, 0, 2'b11);
        step(1, 1, 0, 2'b11);
        check("mid.busy.pre", busy, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid.valid", valid_out, 1'b0);
        check("mid.data",  data_out, 6'd0);
        check("mid.busy",  busy, 1'b0);
        check("mid.cnt",   sym_count, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 2'b11);
            check("mid.fill.valid", valid_out, 1'b0);
        end
        step(1, 1, 0, 2'b11);
        check_sym("mid.s0", 6'b111111, 0, 0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
